// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges of spike_in over a programmable
// window of sample cycles and reports the count, the last inter-spike
// interval and a saturation flag, held under a valid/ready handshake.
module spike_rate_decoder #(
    parameter int WIN_W = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [CNT_W-1:0] isi_out,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W:0]   WIN_ONE = {{WIN_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             prev_q;
    logic [WIN_W:0]   win_q;     // sample cycles left, one extra bit for 2^WIN_W
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] gap_q;     // index distance from the last edge to the current cycle
    logic [CNT_W-1:0] isi_q;
    logic             ovf_q;
    logic             seen_q;    // at least one edge already in this window
    logic [CNT_W-1:0] rate_q, isi_out_q;
    logic             ovf_out_q;

    logic             spike_edge;
    logic             load;
    logic             last;
    logic [WIN_W:0]   win_full;
    logic [CNT_W-1:0] cnt_d, gap_d, isi_d;
    logic             ovf_d, seen_d;

    assign spike_edge = spike_in & ~prev_q;
    assign win_full   = (win_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, win_len};
    assign load       = enable & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign last       = (state_q == COUNT) & enable & (win_q == WIN_ONE);

    assign rate_out = rate_q;
    assign isi_out  = isi_out_q;
    assign overflow = ovf_out_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; dropping enable aborts a window in progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = COUNT;
            COUNT: begin
                if (!enable)   state_d = IDLE;
                else if (last) state_d = HOLD;
            end
            HOLD:    if (out_ready) state_d = enable ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        out_valid = (state_q == HOLD);
        busy      = (state_q == COUNT);
    end

    // Per-sample update of count, interval and overflow, including the current edge
    always_comb begin
        cnt_d  = cnt_q;
        gap_d  = (gap_q == CNT_MAX) ? CNT_MAX : gap_q + CNT_ONE;
        isi_d  = isi_q;
        ovf_d  = ovf_q;
        seen_d = seen_q | spike_edge;
        if (spike_edge) begin
            gap_d = CNT_ONE;
            if (seen_q) isi_d = gap_q;
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Window datapath; results latch only on the final sample cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q    <= 1'b0;
            win_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            isi_q     <= '0;
            ovf_q     <= 1'b0;
            seen_q    <= 1'b0;
            rate_q    <= '0;
            isi_out_q <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            prev_q <= spike_in;
            if (load) begin
                win_q  <= win_full;
                cnt_q  <= '0;
                gap_q  <= '0;
                isi_q  <= '0;
                ovf_q  <= 1'b0;
                seen_q <= 1'b0;
            end else if (state_q == COUNT) begin
                win_q  <= win_q - WIN_ONE;
                cnt_q  <= cnt_d;
                gap_q  <= gap_d;
                isi_q  <= isi_d;
                ovf_q  <= ovf_d;
                seen_q <= seen_d;
                if (last) begin
                    rate_q    <= cnt_d;
                    isi_out_q <= isi_d;
                    ovf_out_q <= ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: reset, basic window, backpressure,
// level spike, saturation, abort, 1024-cycle window and mid-window reset.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       spike_in;
    logic [9:0] win_len;
    logic [7:0] rate_out;
    logic [7:0] isi_out;
    logic       overflow;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    spike_rate_decoder #(.WIN_W(10), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
        .win_len(win_len), .rate_out(rate_out), .isi_out(isi_out),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; spike_in = 1'b0; win_len = 10'd0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_rate",  rate_out, 0);
        chk("rst_isi",   isi_out, 0);
        chk("rst_ovf",   overflow, 0);
        rst = 1'b1;
        tick();

        // Basic window: 10 samples, edges at 2, 6, 9
        enable = 1'b1; win_len = 10'd10;
        tick();
        chk("basic_busy", busy, 1);
        for (int k = 1; k <= 10; k++) begin
            spike_in = (k == 2 || k == 6 || k == 9);
            tick();
            if (k == 9) chk("basic_lat_early", out_valid, 0);
        end
        chk("basic_valid", out_valid, 1);
        chk("basic_busy0", busy, 0);
        chk("basic_rate", rate_out, 3);
        chk("basic_isi",  isi_out, 3);
        chk("basic_ovf",  overflow, 0);

        // Backpressure: 20 cycles of toggling spikes while held
        for (int k = 0; k < 20; k++) begin
            spike_in = k[0];
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_rate",  rate_out, 3);
            chk("bp_isi",   isi_out, 3);
        end

        // Handshake with enable high: next window loads with no gap
        spike_in = 1'b0; out_ready = 1'b1; win_len = 10'd8;
        tick();
        chk("hs_valid_drop", out_valid, 0);
        chk("hs_busy", busy, 1);
        out_ready = 1'b0;

        // Level spike held high across the whole 8-cycle window
        for (int k = 1; k <= 8; k++) begin
            spike_in = 1'b1;
            tick();
        end
        chk("level_valid", out_valid, 1);
        chk("level_rate",  rate_out, 1);
        chk("level_isi",   isi_out, 0);
        out_ready = 1'b1; enable = 1'b0;
        tick();
        chk("level_idle", out_valid | busy, 0);
        out_ready = 1'b0; spike_in = 1'b0;
        tick();

        // Saturation: 600 samples, edges on every odd sample (300 edges)
        enable = 1'b1; win_len = 10'd600;
        tick();
        for (int k = 1; k <= 600; k++) begin
            spike_in = k[0];
            tick();
        end
        chk("sat_valid", out_valid, 1);
        chk("sat_rate",  rate_out, 255);
        chk("sat_isi",   isi_out, 2);
        chk("sat_ovf",   overflow, 1);
        out_ready = 1'b1; enable = 1'b0; spike_in = 1'b0;
        tick();
        out_ready = 1'b0;

        // Abort mid-window: no result, previous outputs kept
        enable = 1'b1; win_len = 10'd10;
        tick();
        for (int k = 1; k <= 4; k++) begin
            spike_in = k[0];
            tick();
        end
        enable = 1'b0; spike_in = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) chk("abort_no_valid", out_valid, 0);
        end
        chk("abort_valid", out_valid, 0);
        chk("abort_rate",  rate_out, 255);
        chk("abort_ovf",   overflow, 1);

        // win_len=0 -> 1024 samples; single edge on the last sample; win_len changed mid-window
        enable = 1'b1; win_len = 10'd0;
        tick();
        win_len = 10'd3;
        for (int k = 1; k <= 1024; k++) begin
            spike_in = (k == 1024);
            tick();
            if (k == 1023) chk("w1024_early", out_valid, 0);
        end
        chk("w1024_valid", out_valid, 1);
        chk("w1024_rate",  rate_out, 1);
        chk("w1024_isi",   isi_out, 0);
        chk("w1024_ovf",   overflow, 0);
        out_ready = 1'b1; enable = 1'b0; spike_in = 1'b0;
        tick();
        out_ready = 1'b0;

        // Reset during COUNT after 5 edges
        enable = 1'b1; win_len = 10'd20;
        tick();
        for (int k = 1; k <= 10; k++) begin
            spike_in = k[0];
            tick();
        end
        rst = 1'b0;
        tick();
        chk("mrst_busy",  busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_rate",  rate_out, 0);
        chk("mrst_isi",   isi_out, 0);
        chk("mrst_ovf",   overflow, 0);
        rst = 1'b1; enable = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid) chk("mrst_no_valid", out_valid, 0);
        end

        // Fresh window after reset counts from zero
        enable = 1'b1; win_len = 10'd4;
        tick();
        for (int k = 1; k <= 4; k++) begin
            spike_in = (k == 2);
            tick();
        end
        chk("post_valid", out_valid, 1);
        chk("post_rate",  rate_out, 1);
        chk("post_isi",   isi_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter WIN_W, default 10: width of the window-length input.
REQ-002 SHALL have parameter CNT_W, default 8: width of the spike-count and interval outputs.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port enable  input  1: run request; high starts and continues windowing.
REQ-006 SHALL have port spike_in  input  1: neuron spike line, level signal, synchronous to clk.
REQ-007 SHALL have port win_len  input  WIN_W: window length in sample cycles; 0 means 2^WIN_W.
REQ-008 SHALL have port rate_out  output  CNT_W: spike count of the last completed window.
REQ-009 SHALL have port isi_out  output  CNT_W: last inter-spike interval of the last completed window.
REQ-010 SHALL have port overflow  output  1: count saturated in the last completed window.
REQ-011 SHALL have port out_valid  output  1: result available.
REQ-012 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-013 SHALL have port busy  output  1: high exactly while in COUNT.

Function
REQ-014 SHALL detect a spike edge in a cycle when spike_in=1 and spike_in in the previous cycle was 0 (previous-sample register resets to 0).
REQ-015 SHALL implement states IDLE, COUNT, HOLD.
REQ-016 IDLE: out_valid=0; if enable=1, load window counter with win_len (0 -> 2^WIN_W), clear count, interval and overflow, and enter COUNT next cycle.
REQ-017 COUNT: every cycle is a sample cycle; a spike edge in that cycle increments the count, and the counter decrements by 1.
REQ-018 Count SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set the window's overflow flag.
REQ-019 Interval SHALL be the difference in sample-cycle index between the two most recent edges in the window, saturating at 2^CNT_W-1.
REQ-020 Interval SHALL be 0 when the window has fewer than 2 edges.
REQ-021 On the last sample cycle, including an edge in that cycle, SHALL register rate_out, isi_out and overflow, and enter HOLD with out_valid=1.
REQ-022 Latency: enable sampled high in IDLE at cycle t gives sample cycles t+1..t+N and out_valid=1 from cycle t+N+1.
REQ-023 HOLD: out_valid, rate_out, isi_out and overflow SHALL stay stable until out_valid and out_ready are both 1.
REQ-024 HOLD: edges SHALL NOT be counted, but the previous-sample register SHALL keep updating.
REQ-025 On a handshake in HOLD: if enable=1, reload win_len and enter COUNT (no gap cycle); otherwise enter IDLE; out_valid SHALL drop the next cycle.
REQ-026 enable=0 during COUNT SHALL abort to IDLE next cycle, produce no result, and leave the previous outputs unchanged.
REQ-027 A change of win_len during COUNT SHALL NOT affect the current window.

Reset
REQ-028 rst=0 at a clock edge SHALL, from any state: enter IDLE; clear rate_out, isi_out, overflow, out_valid, busy and internal counters; and clear the previous-sample register to 0.
REQ-029 A window in progress when reset asserts SHALL be discarded; no out_valid SHALL follow it.

Verification
REQ-030 Reset: rst=0 in COUNT with 5 edges counted -> next cycle all outputs 0, state IDLE; after release and enable, the new window counts from 0.
REQ-031 Basic window: win_len=10, enable at t, 1-cycle spikes at sample cycles 2, 6, 9 -> out_valid at t+11, rate_out=3, isi_out=3, overflow=0.
REQ-032 Level spike: win_len=8, spike_in held high through the entire window -> rate_out=1, isi_out=0.
REQ-033 Saturation: win_len=600, spike_in toggling every cycle -> rate_out=255, overflow=1, isi_out=2.
REQ-034 Backpressure: out_ready=0 for 20 cycles after out_valid, with spikes applied -> outputs stable, extra spikes uncounted; on ready=1 with enable=1, the next window starts the following cycle.
REQ-035 Abort and boundary: enable dropped mid-COUNT -> IDLE, no out_valid; win_len=0 with a single spike on the last sample cycle -> window of 1024 cycles, rate_out=1.
